// File: rtl/db_luma_dec.sv
// Luma deblocking edge decision: buffers one 4-line segment, derives dE/dEp/dEq, replays the lines.
// Optional per-side bypass with protect masks is enabled by defining DB_DEC_BYPASS_EN.
module db_luma_dec #(
    parameter int BIT_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [4:0]               tc_i,
    input  logic [6:0]               beta_i,
    input  logic [1:0]               bs_i,
`ifdef DB_DEC_BYPASS_EN
    input  logic                     bypass_p_i,
    input  logic                     bypass_q_i,
    output logic                     mask_p_o,
    output logic                     mask_q_o,
`endif
    input  logic                     line_valid_i,
    input  logic [8*BIT_DEPTH-1:0]   line_i,
    output logic                     line_ready_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [8*BIT_DEPTH-1:0]   out_line_o,
    output logic [1:0]               out_idx_o,
    output logic [1:0]               de_o,
    output logic                     dep_o,
    output logic                     deq_o,
    output logic [4:0]               tc_o
);
    localparam int LW = 8 * BIT_DEPTH;
    localparam int CW = BIT_DEPTH + 4;

    localparam logic [1:0] ST_ACCEPT = 2'd0;
    localparam logic [1:0] ST_DECIDE = 2'd1;
    localparam logic [1:0] ST_OUTPUT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [4:0]    tc_q, tc_d;
    logic [6:0]    beta_q, beta_d;
    logic [1:0]    bs_q, bs_d;
    logic [1:0]    de_q, de_d;
    logic          dep_q, dep_d, deq_q, deq_d;
    logic [LW-1:0] buf_q [4];

`ifdef DB_DEC_BYPASS_EN
    logic byp_p_q, byp_p_d, byp_q_q, byp_q_d;
    logic mask_p_q, mask_p_d, mask_q_q, mask_q_d;
`endif

    // Sample index 0..7 maps to p3,p2,p1,p0,q0,q1,q2,q3; widened so no intermediate can wrap.
    function automatic logic [CW-1:0] smp(input logic [LW-1:0] line, input int idx);
        return CW'(line[LW-1-idx*BIT_DEPTH -: BIT_DEPTH]);
    endfunction

    function automatic logic [CW-1:0] absd(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic [LW-1:0] edge_line [2];
    logic [CW-1:0] dp [2];
    logic [CW-1:0] dq [2];
    logic [CW-1:0] d_sum, beta_w, beta_side, tc_thr;
    logic [7:0]    tc5;
    logic [1:0]    sam;
    logic [1:0]    dec_de;
    logic          dec_dep, dec_deq;

    assign edge_line[0] = buf_q[0];
    assign edge_line[1] = buf_q[3];

    always_comb begin
        beta_w    = CW'(beta_q);
        beta_side = (beta_w + (beta_w >> 1)) >> 3;
        tc5       = {3'b000, tc_q} * 8'd5 + 8'd1;
        tc_thr    = CW'(tc5 >> 1);
        sam       = '0;
        for (int k = 0; k < 2; k++) begin
            dp[k]  = absd(smp(edge_line[k], 1) + smp(edge_line[k], 3), smp(edge_line[k], 2) << 1);
            dq[k]  = absd(smp(edge_line[k], 6) + smp(edge_line[k], 4), smp(edge_line[k], 5) << 1);
            sam[k] = (((dp[k] + dq[k]) << 1) < (beta_w >> 2)) &&
                     ((absd(smp(edge_line[k], 0), smp(edge_line[k], 3)) +
                       absd(smp(edge_line[k], 4), smp(edge_line[k], 7))) < (beta_w >> 3)) &&
                     (absd(smp(edge_line[k], 3), smp(edge_line[k], 4)) < tc_thr);
        end
        d_sum = dp[0] + dq[0] + dp[1] + dq[1];
        if (bs_q == 2'd0 || d_sum >= beta_w) begin
            dec_de  = 2'd0;
            dec_dep = 1'b0;
            dec_deq = 1'b0;
        end else begin
            dec_de  = (&sam) ? 2'd2 : 2'd1;
            dec_dep = (dp[0] + dp[1]) < beta_side;
            dec_deq = (dq[0] + dq[1]) < beta_side;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tc_d    = tc_q;
        beta_d  = beta_q;
        bs_d    = bs_q;
        de_d    = de_q;
        dep_d   = dep_q;
        deq_d   = deq_q;
`ifdef DB_DEC_BYPASS_EN
        byp_p_d  = byp_p_q;
        byp_q_d  = byp_q_q;
        mask_p_d = mask_p_q;
        mask_q_d = mask_q_q;
`endif
        case (state_q)
            ST_ACCEPT: begin
                if (line_valid_i) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd0) begin
                        tc_d   = tc_i;
                        beta_d = beta_i;
                        bs_d   = bs_i;
`ifdef DB_DEC_BYPASS_EN
                        byp_p_d = bypass_p_i;
                        byp_q_d = bypass_q_i;
`endif
                    end
                    if (cnt_q == 2'd3) state_d = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                de_d    = dec_de;
                dep_d   = dec_dep;
                deq_d   = dec_deq;
`ifdef DB_DEC_BYPASS_EN
                dep_d    = dec_dep & ~byp_p_q;
                deq_d    = dec_deq & ~byp_q_q;
                mask_p_d = byp_p_q;
                mask_q_d = byp_q_q;
`endif
                state_d = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                // Counter wraps 3 -> 0, so the next segment starts at line 0.
                if (out_ready_i) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = ST_ACCEPT;
                end
            end
            default: state_d = ST_ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ACCEPT;
            cnt_q   <= '0;
            tc_q    <= '0;
            beta_q  <= '0;
            bs_q    <= '0;
            de_q    <= '0;
            dep_q   <= 1'b0;
            deq_q   <= 1'b0;
`ifdef DB_DEC_BYPASS_EN
            byp_p_q  <= 1'b0;
            byp_q_q  <= 1'b0;
            mask_p_q <= 1'b0;
            mask_q_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            beta_q  <= beta_d;
            bs_q    <= bs_d;
            de_q    <= de_d;
            dep_q   <= dep_d;
            deq_q   <= deq_d;
`ifdef DB_DEC_BYPASS_EN
            byp_p_q  <= byp_p_d;
            byp_q_q  <= byp_q_d;
            mask_p_q <= mask_p_d;
            mask_q_q <= mask_q_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && state_q == ST_ACCEPT && line_valid_i) buf_q[cnt_q] <= line_i;
    end

    assign line_ready_o = (state_q == ST_ACCEPT);
    assign out_valid_o  = (state_q == ST_OUTPUT);
    assign out_line_o   = out_valid_o ? buf_q[cnt_q] : '0;
    assign out_idx_o    = out_valid_o ? cnt_q : 2'd0;
    assign de_o         = de_q;
    assign dep_o        = dep_q;
    assign deq_o        = deq_q;
    assign tc_o         = tc_q;
`ifdef DB_DEC_BYPASS_EN
    assign mask_p_o     = mask_p_q;
    assign mask_q_o     = mask_q_q;
`endif
endmodule

// File: doc/db_luma_dec.md
Name: db_luma_dec

Overview:
- Deblocking luma edge-decision stage for one 4-line edge segment (4 lines × 8 samples, p3..p0 | q0..q3).
- Sits directly downstream of the tc/beta lookup. Consumes the segment's tc and beta, the segment's boundary strength, and 4 sample lines.
- Buffers the 4 lines, computes the standard HEVC decisions (dE, dEp, dEq), then replays the lines together with the decision to the luma filter stage.

Parameters:
- BIT_DEPTH, 8, sample width in bits.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- tc_i  input  5  tc from the lookup stage; sampled together with line 0
- beta_i  input  7  beta (0..64); sampled together with line 0
- bs_i  input  2  boundary strength; sampled together with line 0
- line_valid_i  input  1  input line valid
- line_i  input  8*BIT_DEPTH  {p3,p2,p1,p0,q0,q1,q2,q3}, p3 in MSBs
- line_ready_o  output  1  block accepts an input line
- out_valid_o  output  1  output line valid
- out_ready_i  input  1  downstream accepts an output line
- out_line_o  output  8*BIT_DEPTH  replayed line, same packing as line_i
- out_idx_o  output  2  line index 0..3 of out_line_o
- de_o  output  2  0 = no filter, 1 = normal, 2 = strong
- dep_o  output  1  modify p1 in normal filter
- deq_o  output  1  modify q1 in normal filter
- tc_o  output  5  tc registered with the segment

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset values: all outputs 0 except line_ready_o=1. FSM returns to ACCEPT, line counter is 0, buffer contents are don't-care. Reset mid-segment discards the partial segment.
- FSM states:
  - ACCEPT: line_ready_o=1. Each line_valid_i cycle stores the line at the counter index and increments the counter. At line 0, tc_i, beta_i and bs_i are registered. After line 3, go to DECIDE.
  - DECIDE: one cycle, line_ready_o=0. Registers the decision outputs, then goes to OUTPUT.
  - OUTPUT: line_ready_o=0, out_valid_o=1. Lines are emitted in order 0..3. A line advances only when out_valid_o && out_ready_i. After line 3 is taken, go to ACCEPT with the counter cleared.
- Latency: line 3 accepted in cycle N gives out_valid_o=1 with line 0 in cycle N+2.
- Output stability: while out_valid_o=1 && !out_ready_i, all outputs hold stable. de_o, dep_o, deq_o and tc_o are stable for the whole OUTPUT phase.
- Decision arithmetic (unsigned, with widening):
  - Per line k ∈ {0,3}: dpk=|p2-2p1+p0| and dqk=|q2-2q1+q0|, each BIT_DEPTH+2 bits.
  - d=dp0+dq0+dp3+dq3, BIT_DEPTH+4 bits.
  - If bs==0 or d>=beta: de=0, dep=0, deq=0.
  - Otherwise, dSamk holds when all three are true:
    - 2*(dpk+dqk) < (beta>>2)
    - |p3-p0|+|q0-q3| < (beta>>3)
    - |p0-q0| < ((5*tc+1)>>1), computed in 8 bits
  - de=2 if dSam0 && dSam3, else de=1.
  - dep = (dp0+dp3) < ((beta+(beta>>1))>>3).
  - deq = (dq0+dq3) < ((beta+(beta>>1))>>3).
  - dep and deq are forced 0 when de==0.
- Boundary values: beta=0 always gives de=0. tc=0 makes the |p0-q0| test always fail, so de is at most 1. A full-scale line (255,0,255 pattern) must not overflow the intermediates.
- line_valid_i outside ACCEPT is ignored; the upstream stage must hold the line until line_ready_o.

Optional Feature:
- Macro: DB_DEC_BYPASS_EN.
- When defined:
  - Adds inputs bypass_p_i and bypass_q_i (1 bit each), sampled with line 0.
  - Adds outputs mask_p_o and mask_q_o, registered in DECIDE and held through OUTPUT.
  - bypass_p_i=1 forces dep_o=0 and mask_p_o=1 (filter must leave P samples unmodified). bypass_q_i is symmetric for the Q side.
  - de_o is unchanged.
- When undefined: none of these ports exist; behaviour is exactly as above.

Test Plan:
- Flat segment, all samples 100, tc=1, beta=64, bs=2 -> de_o=2, dep_o=1, deq_o=1, tc_o=1; out lines equal inputs in order, first out_valid_o 2 cycles after line 3.
- Step edge, p=100 and q=110 on all lines, tc=1, beta=64, bs=2 -> |p0-q0|=10 ≥ 3 gives de_o=1, dep_o=1, deq_o=1.
- Texture: lines 0 and 3 have p2=0, p1=200, p0=0, rest 100, beta=64 -> dp0=400, d ≥ beta, so de_o=0, dep_o=0, deq_o=0.
- Flat segment with bs=0 -> de_o=0. Repeat with beta=0 and bs=2 -> de_o=0.
- Backpressure: hold out_ready_i=0 for 3 cycles while line 1 is presented -> out_line_o, out_idx_o=1 and de_o stay stable; line_ready_o stays 0 until line 3 is taken.
- Reset during ACCEPT after 2 lines -> next cycle all outputs 0 and line_ready_o=1; a fresh 4-line segment decides correctly. With DB_DEC_BYPASS_EN, flat segment plus bypass_p_i=1 -> dep_o=0, mask_p_o=1, deq_o=1.
